// File: rtl/ram_reg_mover.sv
// ram_reg_mover
//   One synchronous single-port RAM, one 2R1W register file and a transfer FSM
//   that moves len words between them (RAM->REG or REG->RAM) without per-word
//   stimulus. When the FSM is idle the external ports give direct access to
//   both storage elements.
//
// Optional feature: define MOVER_CHECKSUM_EN to build a running XOR of every
//   word written to the destination during a transfer. Without it, checksum
//   is tied to zero and no accumulator exists.
//
// Ports
//   clk, resetn                   clock, asynchronous active-low reset
//   start, mode                   transfer request (sampled in IDLE), 0=RAM->REG 1=REG->RAM
//   ram_base, reg_base, len       transfer geometry, latched on accepted start
//   busy, done                    transfer in progress / 1-cycle completion pulse
//   ram_wen, ram_addr, ram_wdata  direct RAM port (writes honoured in IDLE only)
//   ram_rdata                     registered RAM read data (direct or FSM read)
//   raddr1/2, rdata1/2            combinational register reads, always live
//   we, waddr, wdata              direct register write (IDLE only)
//   checksum                      XOR of words moved by the last transfer
module ram_reg_mover #(
  parameter int DATA_W = 32,
  parameter int RAM_AW = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic [RAM_AW-1:0] ram_base,
  input  logic [REG_AW-1:0] reg_base,
  input  logic [REG_AW:0]   len,
  output logic              busy,
  output logic              done,
  input  logic              ram_wen,
  input  logic [RAM_AW-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_rdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] checksum
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam int NREG      = 1 << REG_AW;
  localparam int CNT_W     = REG_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] rf  [NREG];

  logic              mode_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RAM_AW-1:0] ram_base_q;
  logic [REG_AW-1:0] reg_base_q;

  logic              accept;
  logic              cnt_inc;
  logic              idle;
  logic              xfer;

  logic [RAM_AW-1:0] xfer_ram_addr;
  logic [REG_AW-1:0] xfer_reg_idx;
  logic [DATA_W-1:0] rf_src;

  logic [RAM_AW-1:0] ram_addr_mux;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wd;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              vld_p0;
  logic              vld_p1;
  logic [REG_AW-1:0] idx_p1;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_inc = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_d = (len_q == '0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        busy    = 1'b1;
        cnt_inc = 1'b1;
        // RAM->REG needs one extra drain cycle for the read latency, so it
        // leaves at cnt==len; REG->RAM writes in the issue cycle itself.
        if (mode_q ? (cnt_q == len_q - CNT_W'(1)) : (cnt_q == len_q))
          state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= mode;
        len_q  <= len;
        cnt_q  <= '0;
      end else if (cnt_inc) begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ram_base_q <= ram_base;
      reg_base_q <= reg_base;
    end
    idx_p1 <= xfer_reg_idx;
  end

  assign idle = (state_q == S_IDLE);
  assign xfer = (state_q == S_XFER);

  // ---------------------------------------------------------------------
  // Stage p0: address generation, RAM read issue / REG->RAM write
  // ---------------------------------------------------------------------
  assign xfer_ram_addr = ram_base_q + RAM_AW'(cnt_q);
  assign xfer_reg_idx  = reg_base_q + REG_AW'(cnt_q);
  assign rf_src        = rf[xfer_reg_idx];
  assign vld_p0        = xfer & ~mode_q & (cnt_q < len_q);

  always_comb begin
    ram_addr_mux = xfer_ram_addr;
    ram_we       = xfer & mode_q;
    ram_wd       = rf_src;
    if (idle) begin
      ram_addr_mux = ram_addr;
      ram_we       = ram_wen;
      ram_wd       = ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_addr_mux] <= ram_wd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ram_rdata <= '0;
    else
      ram_rdata <= mem[ram_addr_mux];
  end

  // ---------------------------------------------------------------------
  // Stage p1: RAM read data lands in the register file
  // ---------------------------------------------------------------------
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = waddr;
    rf_wdata = wdata;
    if (idle) begin
      rf_we = we;
    end else if (vld_p1) begin
      rf_we    = 1'b1;
      rf_waddr = idx_p1;
      rf_wdata = ram_rdata;
    end
  end

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

`ifdef MOVER_CHECKSUM_EN
  logic              dst_vld;
  logic [DATA_W-1:0] dst_data;
  logic [DATA_W-1:0] csum_q;

  // Words dropped at r0 still count: the accumulator sees the data that was
  // presented to the destination, not what was stored.
  assign dst_vld  = vld_p1 | (xfer & mode_q);
  assign dst_data = vld_p1 ? ram_rdata : rf_src;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      csum_q <= '0;
    else if (accept)
      csum_q <= '0;
    else if (dst_vld)
      csum_q <= csum_q ^ dst_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_reg_mover.sv
// tb_ram_reg_mover
//   Randomized bench for ram_reg_mover with a word-level reference model:
//   plain arrays for the RAM and register file, transfers computed as a loop
//   over k = 0..len-1 with modulo addressing.
module tb_ram_reg_mover;
  localparam int DATA_W = 32;
  localparam int RAM_AW = 16;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam int RDEPTH = 65536;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              mode;
  logic [RAM_AW-1:0] ram_base;
  logic [REG_AW-1:0] reg_base;
  logic [REG_AW:0]   len;
  logic              busy;
  logic              done;
  logic              ram_wen;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [REG_AW-1:0] raddr1;
  logic [REG_AW-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              we;
  logic [REG_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] checksum;

  always #5 clk = ~clk;

  ram_reg_mover #(.DATA_W(DATA_W), .RAM_AW(RAM_AW), .REG_AW(REG_AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .ram_base(ram_base), .reg_base(reg_base), .len(len),
    .busy(busy), .done(done),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata), .checksum(checksum)
  );

  int n_chk = 0;
  int n_err = 0;

  bit [31:0] ram_m [RDEPTH];
  bit        ram_k [RDEPTH];
  bit [31:0] rf_m  [NREG];
  bit [31:0] csum_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_wr(input bit [15:0] a, input bit [31:0] d);
    ram_wen = 1'b1; ram_addr = a; ram_wdata = d;
    tick();
    ram_wen = 1'b0;
    ram_m[a] = d; ram_k[a] = 1'b1;
  endtask

  task automatic reg_wr(input bit [4:0] a, input bit [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
    if (a != 5'd0) rf_m[a] = d;
  endtask

  task automatic ram_chk(input string tag, input bit [15:0] a);
    if (ram_k[a]) begin
      ram_addr = a;
      tick();
      chk(tag, ram_rdata, ram_m[a]);
    end
  endtask

  task automatic regs_chk(input string tag);
    for (int i = 0; i < NREG; i += 2) begin
      raddr1 = 5'(i); raddr2 = 5'(i + 1);
      #1;
      chk({tag, "_rd1"}, rdata1, rf_m[i]);
      chk({tag, "_rd2"}, rdata2, rf_m[i + 1]);
    end
  endtask

  task automatic csum_chk(input string tag);
`ifdef MOVER_CHECKSUM_EN
    chk(tag, checksum, csum_m);
`else
    chk(tag, checksum, 32'h0);
`endif
  endtask

  // One full transfer: optional same-cycle direct writes with start, optional
  // ignored stimulus while busy, then latency, register, RAM and checksum checks.
  task automatic run_xfer(input bit md, input bit [15:0] rb, input bit [4:0] gb,
                          input int ln, input bit inject, input bit pre_wr);
    int        cyc;
    int        exp_lat;
    bit [15:0] ra;
    bit [4:0]  ga;
    bit [31:0] v;
    mode = md; ram_base = rb; reg_base = gb; len = 6'(ln);
    start = 1'b1;
    if (pre_wr) begin
      v = $urandom;
      ram_wen = 1'b1; ram_addr = rb; ram_wdata = v;
      ram_m[rb] = v; ram_k[rb] = 1'b1;
      v = $urandom;
      we = 1'b1; waddr = gb; wdata = v;
      if (gb != 5'd0) rf_m[gb] = v;
    end
    csum_m = 32'h0;
    for (int k = 0; k < ln; k++) begin
      ra = rb + 16'(k);
      ga = gb + 5'(k);
      if (!md) begin
        v = ram_m[ra];
        if (ga != 5'd0) rf_m[ga] = v;
      end else begin
        v = rf_m[ga];
        ram_m[ra] = v; ram_k[ra] = 1'b1;
      end
      csum_m ^= v;
    end
    exp_lat = (ln == 0) ? 2 : (md ? ln + 2 : ln + 3);
    tick();
    start = 1'b0; ram_wen = 1'b0; we = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 32'h1);
    if (inject) begin
      start = 1'b1; mode = ~md; len = 6'($urandom_range(0, 32));
      we = 1'b1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
      ram_wen = 1'b1; ram_addr = 16'($urandom); ram_wdata = $urandom;
      tick();
      start = 1'b0; we = 1'b0; ram_wen = 1'b0;
      cyc++;
    end
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    tick();
    chk("done_pulse_width", 32'(done), 32'h0);
    chk("busy_after_done", 32'(busy), 32'h0);
    regs_chk("regs");
    csum_chk("checksum");
    if (md) begin
      ram_chk("ram_below", rb - 16'd1);
      for (int k = 0; k < ln; k++) ram_chk("ram_dst", rb + 16'(k));
      ram_chk("ram_above", rb + 16'(ln));
    end
    csum_chk("checksum_stable");
  endtask

  initial begin
    int        ln;
    bit        md;
    bit [15:0] rb;
    bit [4:0]  gb;

    resetn = 1'b0; start = 1'b0; mode = 1'b0; ram_base = '0; reg_base = '0; len = '0;
    ram_wen = 1'b0; ram_addr = '0; ram_wdata = '0; raddr1 = '0; raddr2 = '0;
    we = 1'b0; waddr = '0; wdata = '0;
    csum_m = 32'h0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ram_rdata", ram_rdata, 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    regs_chk("rst_regs");
    resetn = 1'b1;
    tick();

    // Direct RAM access and readback latency
    for (int n = 1; n <= 32; n++) ram_wr(16'(n), 32'(n));
    for (int n = 1; n <= 32; n++) ram_chk("direct_ram", 16'(n));

    // Direct register writes, including a dropped write to r0
    reg_wr(5'd0, 32'hDEAD_BEEF);
    reg_wr(5'd7, 32'h1234_5678);
    regs_chk("direct_regs");

    // RAM->REG: rN = N
    run_xfer(1'b0, 16'd1, 5'd1, 31, 1'b0, 1'b0);

    // REG->RAM: rN = 2N copied to 0x100..
    for (int n = 1; n < 32; n++) reg_wr(5'(n), 32'(2 * n));
    run_xfer(1'b1, 16'h0100, 5'd1, 31, 1'b0, 1'b0);

    // Wrap-around in both address spaces
    ram_wr(16'd0, 32'hAAAA_0001);
    ram_wr(16'd1, 32'hBBBB_0002);
    ram_wr(16'd2, 32'hCCCC_0003);
    ram_wr(16'd3, 32'hDDDD_0004);
    run_xfer(1'b0, 16'd0, 5'd30, 4, 1'b0, 1'b0);
    run_xfer(1'b1, 16'hFFFE, 5'd1, 4, 1'b0, 1'b0);

    // Zero-length transfers, start/writes while busy, write+start same cycle
    run_xfer(1'b0, 16'd1, 5'd3, 0, 1'b1, 1'b0);
    run_xfer(1'b1, 16'h0100, 5'd3, 0, 1'b0, 1'b0);
    run_xfer(1'b0, 16'd1, 5'd5, 8, 1'b1, 1'b1);
    run_xfer(1'b1, 16'h0200, 5'd9, 6, 1'b1, 1'b1);

    // Reset in the middle of a RAM->REG transfer
    mode = 1'b0; ram_base = 16'd1; reg_base = 5'd1; len = 6'd31;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) rf_m[i] = 32'h0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_checksum", checksum, 32'h0);
    chk("midrst_ram_rdata", ram_rdata, 32'h0);
    regs_chk("midrst_regs");
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_done", 32'(done), 32'h0);
    end
    run_xfer(1'b0, 16'd1, 5'd1, 31, 1'b0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 20; t++) begin
      md = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       ln = 0;
        1:       ln = 32;
        2:       ln = 1;
        default: ln = $urandom_range(1, 32);
      endcase
      rb = 16'($urandom);
      gb = 5'($urandom);
      if (!md) begin
        for (int k = 0; k < ln; k++) ram_wr(rb + 16'(k), $urandom);
      end else begin
        for (int k = 0; k < 4; k++) reg_wr(5'($urandom), $urandom);
      end
      run_xfer(md, rb, gb, ln, 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
